tree_node_upstream_merge: RTL and testbench

//  Fan-in counterpart to the generated instance tree: each tree node fans out to up to
//  NUM_CHILDREN children, and this block merges the children's upstream result streams

---
 rtl/tree_node_upstream_merge_pkg.sv | 15 +
 rtl/tree_node_upstream_merge_if.sv | 34 +++
 rtl/tree_node_upstream_merge_rr_arbiter.sv | 54 +++++
 rtl/tree_node_upstream_merge.sv | 112 +++++++++++
 tb/tb_tree_node_upstream_merge.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tree_node_upstream_merge_pkg.sv
// Shared types and helpers for the upstream merge node and its arbiter.
package tree_merge_pkg;

    // Output register occupancy: EMPTY means up_valid=0, FULL means a beat is held.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } merge_state_e;

    // Index width that never collapses to zero bits, even for tiny fan-outs.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tree_node_upstream_merge_if.sv
// Child-side and parent-side channels of one merge node, plus FSM debug state.
//
// Handshake semantics (all channels): a beat transfers on a rising clk edge where
// valid and ready are both 1. A source that raised valid keeps valid and data
// stable until that transfer; ready may be computed combinationally from valid
// but valid never depends on ready.
interface tree_merge_if
    import tree_merge_pkg::*;
#(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = 32,
    parameter int ID_W         = clog2_min1(NUM_CHILDREN)
);
    logic [NUM_CHILDREN-1:0]        child_valid;
    logic [NUM_CHILDREN-1:0]        child_ready;
    logic [NUM_CHILDREN*DATA_W-1:0] child_data;
    logic                           up_valid;
    logic                           up_ready;
    logic [DATA_W-1:0]              up_data;
    logic [ID_W-1:0]                up_child_id;
    merge_state_e                   dbg_state;

    // Merge node side: consumes child beats, produces the upstream beat.
    modport master (
        input  child_valid, child_data, up_ready,
        output child_ready, up_valid, up_data, up_child_id, dbg_state
    );

    // Environment side: children and parent around the node.
    modport slave (
        output child_valid, child_data, up_ready,
        input  child_ready, up_valid, up_data, up_child_id, dbg_state
    );
endinterface

// File: rtl/tree_node_upstream_merge_rr_arbiter.sv
// Round-robin arbiter: searches requests starting just after the last grant.
module rr_arbiter
    import tree_merge_pkg::*;
#(
    parameter int N     = 5,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     i_req,
    input  logic             i_adv,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_any
);
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W:0]   w_cand;
    logic [IDX_W-1:0] w_gnt_idx;
    logic             w_any;

    // First requester in rotation order last_grant+1, +2, ... wrapping at N.
    always_comb begin
        w_gnt_idx = '0;
        w_any     = 1'b0;
        w_cand    = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = {1'b0, r_last_grant} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(N)) begin
                w_cand = w_cand - (IDX_W+1)'(N);
            end
            if (!w_any && i_req[w_cand[IDX_W-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_cand[IDX_W-1:0];
            end
        end
    end

    // One-hot view of the grant; zero when nobody requests.
    always_comb begin
        o_gnt     = w_any ? (N'(1) << w_gnt_idx) : '0;
        o_gnt_idx = w_gnt_idx;
        o_any     = w_any;
    end

    // Pointer moves only when a grant is actually consumed; reset favours index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDX_W'(N-1);
        end else if (i_adv) begin
            r_last_grant <= w_gnt_idx;
        end
    end

endmodule

// File: rtl/tree_node_upstream_merge.sv
// Merges NUM_CHILDREN child result streams into one registered upstream stream,
// tagging each beat with its source child index.
module tree_node_upstream_merge
    import tree_merge_pkg::*;
#(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    tree_merge_if.master     bus,
    output logic [CNT_W-1:0] xfer_count
);
    localparam int ID_W = clog2_min1(NUM_CHILDREN);

    merge_state_e              r_state;
    merge_state_e              w_state_nxt;
    logic [DATA_W-1:0]         r_up_data;
    logic [ID_W-1:0]           r_up_child_id;
    logic [CNT_W-1:0]          r_xfer_count;

    logic [NUM_CHILDREN-1:0]   w_gnt;
    logic [ID_W-1:0]           w_gnt_idx;
    logic                      w_any;
    logic                      w_load_en;
    logic                      w_adv;
    logic                      w_up_valid;
    logic                      w_up_xfer;
    logic [DATA_W-1:0]         w_sel_data;

    rr_arbiter #(
        .N     (NUM_CHILDREN),
        .IDX_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.child_valid),
        .i_adv     (w_adv),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // Output register can take a new beat when empty or when its beat leaves now.
    always_comb begin
        w_up_valid = (r_state == FULL);
        w_load_en  = !w_up_valid || bus.up_ready;
        w_adv      = w_load_en && w_any;
        w_up_xfer  = w_up_valid && bus.up_ready;
    end

    // Payload of the granted child.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                w_sel_data = bus.child_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: fill on any request, drain when accepted with nothing new.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_any) w_state_nxt = FULL;
            FULL:    if (bus.up_ready && !w_any) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // FSM outputs: registered upstream beat and the single child ready.
    always_comb begin
        bus.up_valid    = w_up_valid;
        bus.up_data     = r_up_data;
        bus.up_child_id = r_up_child_id;
        bus.child_ready = w_adv ? w_gnt : '0;
        bus.dbg_state   = r_state;
        xfer_count      = r_xfer_count;
    end

    // Capture the granted beat on its child handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_data     <= '0;
            r_up_child_id <= '0;
        end else if (w_adv) begin
            r_up_data     <= w_sel_data;
            r_up_child_id <= w_gnt_idx;
        end
    end

    // Saturating count of completed upstream handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= '0;
        end else if (w_up_xfer && (r_xfer_count != {CNT_W{1'b1}})) begin
            r_xfer_count <= r_xfer_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_tree_node_upstream_merge.sv
// Bench for tree_node_upstream_merge: reference model of the merge rules,
// directed scenarios, random traffic and a saturation check on a narrow counter.
module tb_tree_node_upstream_merge;
    import tree_merge_pkg::*;

    localparam int NC = 5;
    localparam int DW = 32;
    localparam int IW = clog2_min1(NC);

    logic clk;
    logic rst_n;
    logic [15:0] xfer_count;
    logic [3:0]  sat_count;

    tree_merge_if #(.NUM_CHILDREN(NC), .DATA_W(DW)) bus ();
    tree_merge_if #(.NUM_CHILDREN(NC), .DATA_W(DW)) sat_bus ();

    tree_node_upstream_merge #(.NUM_CHILDREN(NC), .DATA_W(DW), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .xfer_count (xfer_count)
    );

    tree_node_upstream_merge #(.NUM_CHILDREN(NC), .DATA_W(DW), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (sat_bus),
        .xfer_count (sat_count)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: the beat sitting in the output register.
    logic [DW-1:0] cdata [NC];
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_id;
    int            m_last;
    int            m_cnt;

    function automatic int find_grant(input logic [NC-1:0] v, input int last);
        for (int k = 1; k <= NC; k++) begin
            if (v[(last + k) % NC]) return (last + k) % NC;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_id    = 0;
        m_last  = NC - 1;
        m_cnt   = 0;
    endtask

    task automatic rand_cdata();
        for (int i = 0; i < NC; i++) cdata[i] = $urandom;
    endtask

    // One clock cycle: drive, check ready, advance model, check registered outputs.
    task automatic step(input logic [NC-1:0] v, input logic rdy);
        logic [NC-1:0] exp_rdy;
        bit load;
        int g;
        for (int i = 0; i < NC; i++) bus.child_data[i*DW +: DW] = cdata[i];
        bus.child_valid = v;
        bus.up_ready    = rdy;
        #1;
        load = !m_valid || rdy;
        g = find_grant(v, m_last);
        exp_rdy = '0;
        if (load && g >= 0) exp_rdy[g] = 1'b1;
        n_vec++;
        if (bus.child_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL child_ready: got %b expected %b", bus.child_ready, exp_rdy);
        end
        if (m_valid && rdy && m_cnt != 16'hFFFF) m_cnt++;
        if (load) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = cdata[g];
                m_id    = g;
                m_last  = g;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.up_valid !== m_valid) begin
            n_err++;
            $display("FAIL up_valid: got %b expected %b", bus.up_valid, m_valid);
        end
        n_vec++;
        if (xfer_count !== 16'(m_cnt)) begin
            n_err++;
            $display("FAIL xfer_count: got %0d expected %0d", xfer_count, m_cnt);
        end
        if (m_valid) begin
            n_vec++;
            if (bus.up_data !== m_data || bus.up_child_id !== IW'(m_id)) begin
                n_err++;
                $display("FAIL up_beat: got id %0d data %h expected id %0d data %h",
                         bus.up_child_id, bus.up_data, m_id, m_data);
            end
        end
    endtask

    task automatic do_reset();
        bus.child_valid = '0;
        bus.up_ready    = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (bus.up_valid !== 1'b0 || bus.up_data !== '0 || bus.up_child_id !== '0 ||
            xfer_count !== '0 || bus.dbg_state !== EMPTY) begin
            n_err++;
            $display("FAIL reset_state: got v=%b d=%h id=%0d cnt=%0d expected all zero",
                     bus.up_valid, bus.up_data, bus.up_child_id, xfer_count);
        end
    endtask

    task automatic test_single_child();
        do_reset();
        rand_cdata();
        cdata[2] = 32'hA5A5_0002;
        step(5'b00100, 1'b1);
        n_vec++;
        if (bus.up_valid !== 1'b1 || bus.up_child_id !== 3'd2 || bus.up_data !== 32'hA5A5_0002) begin
            n_err++;
            $display("FAIL single_child: got v=%b id=%0d d=%h expected v=1 id=2 d=a5a50002",
                     bus.up_valid, bus.up_child_id, bus.up_data);
        end
        step(5'b00000, 1'b1);
        n_vec++;
        if (xfer_count !== 16'd1) begin
            n_err++;
            $display("FAIL single_count: got %0d expected 1", xfer_count);
        end
    endtask

    task automatic test_rotate();
        int rot_exp [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rand_cdata();
            step(5'b11111, 1'b1);
            n_vec++;
            if (bus.up_valid !== 1'b1 || bus.up_child_id !== IW'(rot_exp[i])) begin
                n_err++;
                $display("FAIL rotate[%0d]: got v=%b id=%0d expected v=1 id=%0d",
                         i, bus.up_valid, bus.up_child_id, rot_exp[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [DW-1:0] held_data;
        do_reset();
        rand_cdata();
        step(5'b01000, 1'b0);
        held_data = bus.up_data;
        for (int i = 0; i < 4; i++) begin
            rand_cdata();
            step(5'b11111, 1'b0);
            n_vec++;
            if (bus.up_data !== held_data || bus.up_child_id !== 3'd3 || bus.child_ready !== '0) begin
                n_err++;
                $display("FAIL hold[%0d]: got id=%0d d=%h rdy=%b expected id=3 d=%h rdy=0",
                         i, bus.up_child_id, bus.up_data, bus.child_ready, held_data);
            end
        end
        rand_cdata();
        step(5'b00001, 1'b1);
        n_vec++;
        if (bus.up_valid !== 1'b1 || bus.up_child_id !== 3'd0 || xfer_count !== 16'd1) begin
            n_err++;
            $display("FAIL hold_release: got v=%b id=%0d cnt=%0d expected v=1 id=0 cnt=1",
                     bus.up_valid, bus.up_child_id, xfer_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rand_cdata();
        step(5'b00010, 1'b1);
        step(5'b10001, 1'b1);
        n_vec++;
        if (bus.up_child_id !== 3'd4) begin
            n_err++;
            $display("FAIL wrap_first: got id=%0d expected 4", bus.up_child_id);
        end
        step(5'b00001, 1'b1);
        n_vec++;
        if (bus.up_child_id !== 3'd0) begin
            n_err++;
            $display("FAIL wrap_second: got id=%0d expected 0", bus.up_child_id);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rand_cdata();
            step(5'b11111, 1'b1);
        end
        step(5'b00010, 1'b0);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.up_valid !== 1'b0 || xfer_count !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b cnt=%0d expected v=0 cnt=0", bus.up_valid, xfer_count);
        end
        model_reset();
        bus.child_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_cdata();
        step(5'b01001, 1'b1);
        n_vec++;
        if (bus.up_child_id !== 3'd0) begin
            n_err++;
            $display("FAIL reset_regrant_first: got id=%0d expected 0", bus.up_child_id);
        end
        step(5'b01000, 1'b1);
        n_vec++;
        if (bus.up_child_id !== 3'd3) begin
            n_err++;
            $display("FAIL reset_regrant_second: got id=%0d expected 3", bus.up_child_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_cdata();
            step(NC'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        sat_bus.child_valid = 5'b00010;
        sat_bus.up_ready    = 1'b1;
        for (int j = 1; j <= 22; j++) begin
            sat_bus.child_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            exp_cnt = (j - 1 > 15) ? 15 : j - 1;
            n_vec++;
            if (sat_count !== 4'(exp_cnt) || sat_bus.up_valid !== 1'b1) begin
                n_err++;
                $display("FAIL saturation[%0d]: got cnt=%0d v=%b expected cnt=%0d v=1",
                         j, sat_count, sat_bus.up_valid, exp_cnt);
            end
        end
        sat_bus.child_valid = '0;
        sat_bus.up_ready    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.child_valid     = '0;
        bus.child_data      = '0;
        bus.up_ready        = 1'b0;
        sat_bus.child_valid = '0;
        sat_bus.child_data  = '0;
        sat_bus.up_ready    = 1'b0;
        for (int i = 0; i < NC; i++) cdata[i] = '0;
        model_reset();
        #12;
        test_reset();
        test_single_child();
        test_rotate();
        test_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
